// File: rtl/fifo_pkg.sv
// Types shared by the matrix FIFO controller, its RAM and the wrapper.
package fifo_pkg;
   import global_pkg::*;

   localparam int M_ADDR_W = $clog2(MATRIX_SIZE);

   typedef logic [M_ADDR_W-1:0] M_address_t;  // RAM address / pointer
   typedef logic [7:0]          data_t;       // one stored matrix element
   typedef logic [M_ADDR_W:0]   occ_t;        // occupancy, 0..MATRIX_SIZE
endpackage : fifo_pkg

// File: rtl/global_pkg.sv
// Project-wide sizing constants shared by the matrix datapath blocks.
package global_pkg;
   // Number of entries held by each matrix FIFO.
   localparam int MATRIX_SIZE = 4;
endpackage : global_pkg

// File: rtl/matrix_fifo.sv
// Matrix FIFO: controller plus its storage array.
module matrix_fifo
   import global_pkg::*;
   import fifo_pkg::*;
#(
   parameter int DEPTH  = MATRIX_SIZE,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              push,
   input  logic              pop,
   input  data_t             data_in,
   output data_t             data_out,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   occupancy,
   output logic              data_valid,
   output logic              overflow,
   output logic              underflow
);

   logic              wr_en;
   logic              rd_en;
   logic [ADDR_W-1:0] count_push;
   logic [ADDR_W-1:0] count_pop;

   matrix_fifo_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ctrl (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear),
      .push       (push),
      .pop        (pop),
      .wr_en      (wr_en),
      .rd_en      (rd_en),
      .count_push (count_push),
      .count_pop  (count_pop),
      .full       (full),
      .empty      (empty),
      .occupancy  (occupancy),
      .data_valid (data_valid),
      .overflow   (overflow),
      .underflow  (underflow)
   );

   ram_matrix #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
      .clk      (clk),
      .wr_en    (wr_en),
      .rd_en    (rd_en),
      .wr_addr  (count_push),
      .rd_addr  (count_pop),
      .data_in  (data_in),
      .data_out (data_out)
   );

endmodule : matrix_fifo

// File: rtl/ram_matrix.sv
// Storage array for the matrix FIFO: one write port, one registered read
// port. A read and write to the same address in one cycle returns the old
// contents (read-before-write).
module ram_matrix
   import fifo_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [ADDR_W-1:0] rd_addr,
   input  data_t             data_in,
   output data_t             data_out
);

   data_t mem [DEPTH];

   // Write and registered read; nonblocking update gives read-before-write.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= data_in;
      if (rd_en)
         data_out <= mem[rd_addr];
   end

endmodule : ram_matrix

// File: rtl/wrap_counter.sv
// Modulo-DEPTH pointer: counts 0..DEPTH-1 and wraps by explicit compare,
// so DEPTH need not be a power of two.
module wrap_counter #(
   parameter int DEPTH = 4,
   parameter int W     = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] LAST = W'(DEPTH - 1);

   // Pointer register: reset/clear to 0, advance on inc, wrap at DEPTH-1.
   always_ff @(posedge clk) begin
      if (rst || clr)
         count <= '0;
      else if (inc)
         count <= (count == LAST) ? '0 : count + 1'b1;
   end

endmodule : wrap_counter

// File: rtl/matrix_fifo_ctrl.sv
// Pointer/flag controller for a matrix FIFO. Converts push/pop requests
// into RAM write/read strobes and addresses, tracks occupancy, raises
// full/empty, marks the cycle the RAM read data is valid and keeps sticky
// overflow/underflow flags.
module matrix_fifo_ctrl
   import global_pkg::*;
#(
   parameter int DEPTH  = MATRIX_SIZE,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              push,
   input  logic              pop,
   output logic              wr_en,
   output logic              rd_en,
   output logic [ADDR_W-1:0] count_push,
   output logic [ADDR_W-1:0] count_pop,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   occupancy,
   output logic              data_valid,
   output logic              overflow,
   output logic              underflow
);

   localparam logic [ADDR_W:0] OCC_FULL = (ADDR_W+1)'(DEPTH);

   logic active;
   logic pop_ok;
   logic push_ok;

   // Flags come only from the occupancy register, never from push/pop.
   assign full  = (occupancy == OCC_FULL);
   assign empty = (occupancy == '0);

   // Accept decisions. Reset and clear win over requests, so neither strobe
   // can fire while they are high. A pop frees a slot in the same cycle,
   // letting a push into a full FIFO through; an empty FIFO has no bypass.
   assign active  = ~rst & ~clear;
   assign pop_ok  = active & pop & ~empty;
   assign push_ok = active & push & (~full | pop_ok);
   assign wr_en   = push_ok;
   assign rd_en   = pop_ok;

   wrap_counter #(.DEPTH(DEPTH), .W(ADDR_W)) u_push_ptr (
      .clk   (clk),
      .rst   (rst),
      .clr   (clear),
      .inc   (push_ok),
      .count (count_push)
   );

   wrap_counter #(.DEPTH(DEPTH), .W(ADDR_W)) u_pop_ptr (
      .clk   (clk),
      .rst   (rst),
      .clr   (clear),
      .inc   (pop_ok),
      .count (count_pop)
   );

   // Occupancy: +1 push only, -1 pop only, hold when both or neither.
   always_ff @(posedge clk) begin
      if (rst || clear)
         occupancy <= '0;
      else if (push_ok && !pop_ok)
         occupancy <= occupancy + 1'b1;
      else if (pop_ok && !push_ok)
         occupancy <= occupancy - 1'b1;
   end

   // Read data is valid the cycle after an accepted pop (RAM read latency).
   always_ff @(posedge clk) begin
      if (rst || clear)
         data_valid <= 1'b0;
      else
         data_valid <= pop_ok;
   end

   // Sticky error flags; only reset clears them, clear leaves them alone.
   // Requests masked by clear are ignored and do not count as errors.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (active && push && full && !pop_ok)
            overflow <= 1'b1;
         if (active && pop && empty)
            underflow <= 1'b1;
      end
   end

endmodule : matrix_fifo_ctrl

// File: tb/tb_matrix_fifo_ctrl.sv
// Directed bench for matrix_fifo_ctrl with DEPTH=4, paired with ram_matrix
// so stored data order is checked end to end.
module tb_matrix_fifo_ctrl;
   import fifo_pkg::*;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = 2;

   logic              clk = 1'b0;
   logic              rst, clear, push, pop;
   logic              wr_en, rd_en, full, empty, data_valid, overflow, underflow;
   logic [ADDR_W-1:0] count_push, count_pop;
   logic [ADDR_W:0]   occupancy;
   data_t             data_in, data_out;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   matrix_fifo_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear),
      .push       (push),
      .pop        (pop),
      .wr_en      (wr_en),
      .rd_en      (rd_en),
      .count_push (count_push),
      .count_pop  (count_pop),
      .full       (full),
      .empty      (empty),
      .occupancy  (occupancy),
      .data_valid (data_valid),
      .overflow   (overflow),
      .underflow  (underflow)
   );

   ram_matrix #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
      .clk      (clk),
      .wr_en    (wr_en),
      .rd_en    (rd_en),
      .wr_addr  (count_push),
      .rd_addr  (count_pop),
      .data_in  (data_in),
      .data_out (data_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge and sample 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input data_t v);
      push = 1'b1; data_in = v;
      #1 chk("push_wr_en", 32'(wr_en), 1);
      tick();
      push = 1'b0;
   endtask

   task automatic pop_exp(input data_t v);
      pop = 1'b1;
      #1 chk("pop_rd_en", 32'(rd_en), 1);
      tick();
      pop = 1'b0;
      chk("pop_valid", 32'(data_valid), 1);
      chk("pop_data", 32'(data_out), 32'(v));
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;

      // 1. reset then idle
      push = 1'b1; pop = 1'b1;
      tick();
      #1;
      chk("rst_wr_en", 32'(wr_en), 0);
      chk("rst_rd_en", 32'(rd_en), 0);
      push = 1'b0; pop = 1'b0;
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_occ", 32'(occupancy), 0);
      chk("rst_cpush", 32'(count_push), 0);
      chk("rst_cpop", 32'(count_pop), 0);
      chk("rst_dv", 32'(data_valid), 0);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_unf", 32'(underflow), 0);
      rst = 1'b0;
      tick(); tick();
      chk("idle_wr_en", 32'(wr_en), 0);
      chk("idle_rd_en", 32'(rd_en), 0);
      chk("idle_empty", 32'(empty), 1);

      // 2. fill then drain
      push_one(8'h11); push_one(8'h22); push_one(8'h33);
      chk("fill3_full", 32'(full), 0);
      push_one(8'h44);
      chk("fill_full", 32'(full), 1);
      chk("fill_occ", 32'(occupancy), 4);
      chk("fill_cpush_wrap", 32'(count_push), 0);
      pop_exp(8'h11); pop_exp(8'h22); pop_exp(8'h33); pop_exp(8'h44);
      chk("drain_empty", 32'(empty), 1);
      chk("drain_cpop_wrap", 32'(count_pop), 0);
      tick();
      chk("drain_dv_low", 32'(data_valid), 0);

      // 3. full with simultaneous push and pop
      push_one(8'h11); push_one(8'h22); push_one(8'h33); push_one(8'h44);
      push = 1'b1; pop = 1'b1; data_in = 8'h55;
      #1;
      chk("fpp_wr_en", 32'(wr_en), 1);
      chk("fpp_rd_en", 32'(rd_en), 1);
      chk("fpp_same_addr", 32'(count_push), 32'(count_pop));
      tick();
      push = 1'b0; pop = 1'b0;
      chk("fpp_data", 32'(data_out), 8'h11);
      chk("fpp_dv", 32'(data_valid), 1);
      chk("fpp_occ", 32'(occupancy), 4);
      pop_exp(8'h22); pop_exp(8'h33); pop_exp(8'h44); pop_exp(8'h55);
      chk("fpp_empty", 32'(empty), 1);

      // 4. errors: pointers now at 1/1
      push_one(8'h11); push_one(8'h22); push_one(8'h33); push_one(8'h44);
      push = 1'b1; data_in = 8'h99;
      #1 chk("ovf_wr_en", 32'(wr_en), 0);
      tick();
      push = 1'b0;
      chk("ovf_flag", 32'(overflow), 1);
      chk("ovf_occ", 32'(occupancy), 4);
      chk("ovf_cpush", 32'(count_push), 1);
      pop_exp(8'h11); pop_exp(8'h22); pop_exp(8'h33); pop_exp(8'h44);
      pop = 1'b1;
      #1 chk("unf_rd_en", 32'(rd_en), 0);
      tick();
      pop = 1'b0;
      chk("unf_flag", 32'(underflow), 1);
      chk("unf_dv", 32'(data_valid), 0);
      chk("unf_occ", 32'(occupancy), 0);
      tick();
      chk("ovf_sticky", 32'(overflow), 1);
      chk("unf_sticky", 32'(underflow), 1);

      // 5. empty with simultaneous push and pop
      push = 1'b1; pop = 1'b1; data_in = 8'h77;
      #1;
      chk("epp_wr_en", 32'(wr_en), 1);
      chk("epp_rd_en", 32'(rd_en), 0);
      tick();
      push = 1'b0; pop = 1'b0;
      chk("epp_occ", 32'(occupancy), 1);
      chk("epp_unf", 32'(underflow), 1);
      chk("epp_dv", 32'(data_valid), 0);
      pop_exp(8'h77);

      // 6. clear, then reset
      push_one(8'hA1); push_one(8'hA2); push_one(8'hA3);
      chk("clr_pre_occ", 32'(occupancy), 3);
      clear = 1'b1; push = 1'b1; data_in = 8'hEE;
      #1 chk("clr_wr_en", 32'(wr_en), 0);
      tick();
      clear = 1'b0; push = 1'b0;
      chk("clr_occ", 32'(occupancy), 0);
      chk("clr_cpush", 32'(count_push), 0);
      chk("clr_cpop", 32'(count_pop), 0);
      chk("clr_empty", 32'(empty), 1);
      chk("clr_ovf", 32'(overflow), 1);
      chk("clr_unf", 32'(underflow), 1);
      push_one(8'hB1); push_one(8'hB2);
      chk("pre_rst_occ", 32'(occupancy), 2);
      pop_exp(8'hB1);
      // reset mid-stream: pop held high through reset is ignored
      push_one(8'hB3);
      pop = 1'b1;
      tick();
      chk("midrst_dv", 32'(data_valid), 1);
      chk("midrst_data", 32'(data_out), 8'hB2);
      rst = 1'b1;
      #1 chk("rst2_rd_en", 32'(rd_en), 0);
      tick();
      pop = 1'b0;
      rst = 1'b0;
      chk("rst2_dv", 32'(data_valid), 0);
      chk("rst2_occ", 32'(occupancy), 0);
      chk("rst2_empty", 32'(empty), 1);
      chk("rst2_full", 32'(full), 0);
      chk("rst2_cpush", 32'(count_push), 0);
      chk("rst2_cpop", 32'(count_pop), 0);
      chk("rst2_ovf", 32'(overflow), 0);
      chk("rst2_unf", 32'(underflow), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_matrix_fifo_ctrl
